// File: rtl/vector_frame_engine.sv
// vector_frame_engine: display-list driven vector beam engine (title/game frames, crosshair, DAC codes)
module vector_frame_engine #(
  parameter int ADDRESSWIDTH = 8,
  parameter int DATAWIDTH = 18,
  parameter int OUT_WIDTH = 8,
  parameter int TICK_DIV = 25,
  parameter int HALT_TICKS = 4
) (
  input  logic                 clk_fast,
  input  logic                 rst,
  input  logic                 startgame,
  input  logic [7:0]           xcursor,
  input  logic [7:0]           ycursor,
  output logic                 go_flag,
  output logic                 halt_flag,
  output logic [OUT_WIDTH-1:0] xch,
  output logic [OUT_WIDTH-1:0] ych
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HALT_TICKS > 1) ? $clog2(HALT_TICKS) : 1;
  localparam logic [ADDRESSWIDTH-1:0] GAME = {1'b1, {(ADDRESSWIDTH-1){1'b0}}};
  localparam logic [1:0] OP_MOVE = 2'd0, OP_LINE = 2'd1, OP_CURS = 2'd2, OP_HALT = 2'd3;
  typedef enum logic [2:0] {START, FETCH, EXEC, STEP, CROSS, HALT} state_t;
  typedef struct packed {
    logic [7:0]         dx;
    logic [7:0]         dy;
    logic               sx;
    logic               sy;
    logic signed [10:0] err;
  } line_t;
  function automatic line_t line_init(input logic [7:0] x0, y0, x1, y1);
    line_t l;
    l.sx = x1 < x0;
    l.sy = y1 < y0;
    l.dx = l.sx ? x0 - x1 : x1 - x0;
    l.dy = l.sy ? y0 - y1 : y1 - y0;
    l.err = $signed({3'b0, l.dx}) - $signed({3'b0, l.dy});
    return l;
  endfunction
  function automatic logic [7:0] lo4(input logic [7:0] v);
    return (v < 8'd4) ? 8'd0 : v - 8'd4;
  endfunction
  function automatic logic [7:0] hi4(input logic [7:0] v);
    return (v > 8'd251) ? 8'd255 : v + 8'd4;
  endfunction
  function automatic logic [DATAWIDTH-1:0] w(input logic [1:0] op, input logic [7:0] x, y);
    return DATAWIDTH'({op, x, y});
  endfunction
  state_t                    state_q;
  logic [CW-1:0]             cnt_q;
  logic [HW-1:0]             hcnt_q;
  logic [ADDRESSWIDTH-1:0]   pc_q;
  logic [DATAWIDTH-1:0]      rom_q, rom_d;
  logic [7:0]                bx_q, by_q, tx_q, ty_q, cx_q, cy_q;
  logic                      cross_q;
  line_t                     ln_q;
  logic                      tick, xs, ys, arrive;
  logic signed [11:0]        e2, dxs, dys;
  logic signed [10:0]        err_d;
  logic [7:0]                bx_d, by_d, cur_x, cur_y, sx0, sy0, ex, ey;
  logic [1:0]                op;
  logic [7:0]                rx, ry;
  assign tick = cnt_q == CW'(TICK_DIV - 1);
  assign op = rom_q[17:16];
  assign rx = rom_q[15:8];
  assign ry = rom_q[7:0];
  assign xch = OUT_WIDTH'(bx_q) << (OUT_WIDTH - 8);
  assign ych = OUT_WIDTH'(by_q) << (OUT_WIDTH - 8);
  always_comb begin
    case (pc_q)
      ADDRESSWIDTH'(0):        rom_d = w(OP_MOVE, 8'd64, 8'd64);
      ADDRESSWIDTH'(1):        rom_d = w(OP_LINE, 8'd192, 8'd64);
      ADDRESSWIDTH'(2):        rom_d = w(OP_LINE, 8'd192, 8'd192);
      ADDRESSWIDTH'(3):        rom_d = w(OP_LINE, 8'd64, 8'd192);
      ADDRESSWIDTH'(4):        rom_d = w(OP_LINE, 8'd64, 8'd64);
      GAME:                    rom_d = w(OP_MOVE, 8'd0, 8'd0);
      GAME + ADDRESSWIDTH'(1): rom_d = w(OP_LINE, 8'd255, 8'd0);
      GAME + ADDRESSWIDTH'(2): rom_d = w(OP_LINE, 8'd255, 8'd255);
      GAME + ADDRESSWIDTH'(3): rom_d = w(OP_LINE, 8'd0, 8'd255);
      GAME + ADDRESSWIDTH'(4): rom_d = w(OP_LINE, 8'd0, 8'd0);
      GAME + ADDRESSWIDTH'(5): rom_d = w(OP_CURS, 8'd0, 8'd0);
      default:                 rom_d = w(OP_HALT, 8'd0, 8'd0);
    endcase
  end
  // Bresenham step: dy is kept as a magnitude, so the classic "e2 >= dy" test becomes "e2 >= -dy"
  always_comb begin
    e2 = {ln_q.err, 1'b0};
    dxs = {4'b0, ln_q.dx};
    dys = {4'b0, ln_q.dy};
    xs = e2 >= -dys;
    ys = e2 <= dxs;
    bx_d = xs ? (ln_q.sx ? bx_q - 8'd1 : bx_q + 8'd1) : bx_q;
    by_d = ys ? (ln_q.sy ? by_q - 8'd1 : by_q + 8'd1) : by_q;
    err_d = 11'(ln_q.err - (xs ? dys : 12'sd0) + (ys ? dxs : 12'sd0));
    arrive = (bx_d == tx_q) && (by_d == ty_q);
  end
  // cross_q low: horizontal stroke from the live cursor; high: vertical stroke from the latched cursor
  always_comb begin
    cur_x = cross_q ? cx_q : xcursor;
    cur_y = cross_q ? cy_q : ycursor;
    sx0 = cross_q ? cur_x : lo4(cur_x);
    sy0 = cross_q ? lo4(cur_y) : cur_y;
    ex = cross_q ? cur_x : hi4(cur_x);
    ey = cross_q ? hi4(cur_y) : cur_y;
  end
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      hcnt_q <= '0;
      state_q <= START;
      pc_q <= '0;
      rom_q <= '0;
      bx_q <= '0;
      by_q <= '0;
      tx_q <= '0;
      ty_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      cross_q <= 1'b0;
      ln_q <= '0;
      go_flag <= 1'b0;
      halt_flag <= 1'b0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        case (state_q)
          START: begin
            pc_q <= startgame ? GAME : '0;
            go_flag <= 1'b1;
            state_q <= FETCH;
          end
          FETCH: begin
            rom_q <= rom_d;
            pc_q <= pc_q + 1'b1;
            state_q <= EXEC;
          end
          EXEC: begin
            case (op)
              OP_MOVE: begin
                bx_q <= rx;
                by_q <= ry;
                state_q <= FETCH;
              end
              OP_LINE: begin
                tx_q <= rx;
                ty_q <= ry;
                ln_q <= line_init(bx_q, by_q, rx, ry);
                state_q <= (rx == bx_q && ry == by_q) ? FETCH : STEP;
              end
              OP_CURS: state_q <= CROSS;
              default: begin
                go_flag <= 1'b0;
                halt_flag <= 1'b1;
                hcnt_q <= '0;
                state_q <= HALT;
              end
            endcase
          end
          STEP: begin
            bx_q <= bx_d;
            by_q <= by_d;
            ln_q.err <= err_d;
            if (arrive) state_q <= cross_q ? CROSS : FETCH;
          end
          CROSS: begin
            cx_q <= cur_x;
            cy_q <= cur_y;
            bx_q <= sx0;
            by_q <= sy0;
            tx_q <= ex;
            ty_q <= ey;
            ln_q <= line_init(sx0, sy0, ex, ey);
            cross_q <= !cross_q;
            state_q <= STEP;
          end
          HALT: begin
            // go_flag rises as halt_flag falls so the two stay complementary across frames
            if (hcnt_q == HW'(HALT_TICKS - 1)) begin
              halt_flag <= 1'b0;
              go_flag <= 1'b1;
              state_q <= START;
            end else hcnt_q <= hcnt_q + 1'b1;
          end
          default: state_q <= START;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vector_frame_engine.sv
// tb_vector_frame_engine: scoreboard bench walking title, mode-switch, game and clamped-crosshair frames
module tb_vector_frame_engine;
  logic clk_fast = 1'b0, rst = 1'b1, startgame = 1'b0;
  logic [7:0] xcursor = 8'd150, ycursor = 8'd150;
  logic go_flag, halt_flag;
  logic [7:0] xch, ych;
  typedef struct packed { logic [7:0] x; logic [7:0] y; } pt_t;
  pt_t exp_q[$];
  int total = 0, bad = 0, jumps = 0, viol = 0;
  time min_gap = 1000000, last_t = 0, rel_t = 0;
  logic [7:0] px = 8'd0, py = 8'd0;
  bit seen_go = 0;
  vector_frame_engine dut (
    .clk_fast(clk_fast), .rst(rst), .startgame(startgame),
    .xcursor(xcursor), .ycursor(ycursor),
    .go_flag(go_flag), .halt_flag(halt_flag), .xch(xch), .ych(ych)
  );
  always #5 clk_fast = ~clk_fast;
  function automatic int ad(input int a, input int b);
    return a > b ? a - b : b - a;
  endfunction
  always @(negedge clk_fast) begin
    if (rst) begin
      px = 8'd0;
      py = 8'd0;
      seen_go = 0;
      last_t = $time;
    end else begin
      if (xch !== px || ych !== py) begin
        if (ad(int'(xch), int'(px)) > 1 || ad(int'(ych), int'(py)) > 1) jumps++;
        if ($time - last_t < min_gap) min_gap = $time - last_t;
        last_t = $time;
        px = xch;
        py = ych;
      end
      if (exp_q.size() > 0 && xch == exp_q[0].x && ych == exp_q[0].y) void'(exp_q.pop_front());
      if (seen_go && go_flag === halt_flag) viol++;
      if (go_flag) seen_go = 1;
    end
  end
  task automatic push(input int x, input int y);
    exp_q.push_back('{x: 8'(x), y: 8'(y)});
  endtask
  task automatic push_border();
    push(0, 0); push(255, 0); push(255, 255); push(0, 255); push(0, 0);
  endtask
  task automatic wait_rise(input int lim, output bit ok);
    int n = 0;
    ok = 0;
    while (n < lim && !ok) begin
      @(negedge clk_fast);
      n++;
      ok = halt_flag;
    end
  endtask
  task automatic wait_fall(output int len);
    len = 1;
    while (halt_flag && len < 1000) begin
      @(negedge clk_fast);
      if (halt_flag) len++;
    end
  endtask
  task automatic test_reset();
    int n;
    repeat (3) @(negedge clk_fast);
    total++; if (xch !== 8'd0) begin bad++; $display("FAIL init_xch got %0d want 0", xch); end
    total++; if (ych !== 8'd0) begin bad++; $display("FAIL init_ych got %0d want 0", ych); end
    total++; if (go_flag !== 1'b0) begin bad++; $display("FAIL init_go got %b want 0", go_flag); end
    total++; if (halt_flag !== 1'b0) begin bad++; $display("FAIL init_halt got %b want 0", halt_flag); end
    rst = 1'b0;
    repeat (3000) @(negedge clk_fast);
    @(posedge clk_fast);
    #3 rst = 1'b1;
    #1;
    total++; if (xch !== 8'd0) begin bad++; $display("FAIL async_xch got %0d want 0", xch); end
    total++; if (ych !== 8'd0) begin bad++; $display("FAIL async_ych got %0d want 0", ych); end
    total++; if (go_flag !== 1'b0) begin bad++; $display("FAIL async_go got %b want 0", go_flag); end
    total++; if (halt_flag !== 1'b0) begin bad++; $display("FAIL async_halt got %b want 0", halt_flag); end
    repeat (3) @(negedge clk_fast);
    rst = 1'b0;
    rel_t = $time;
    n = 0;
    while (go_flag !== 1'b1 && n < 100) begin
      @(negedge clk_fast);
      n++;
    end
    total++; if (go_flag !== 1'b1 || n > 50) begin bad++; $display("FAIL go_after_reset got %0d cycles want <=50", n); end
  endtask
  task automatic test_title();
    bit ok;
    int len;
    exp_q.delete();
    push(64, 64); push(192, 64); push(192, 192); push(64, 192); push(64, 64);
    jumps = 0;
    wait_rise(600 * 25, ok);
    total++; if (!ok || $time - rel_t > 540 * 250) begin bad++; $display("FAIL title_halt_time got %0t want <=%0d", $time - rel_t, 540 * 250); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL title_points got %0d left want 0", exp_q.size()); end
    total++; if (jumps != 1) begin bad++; $display("FAIL title_jumps got %0d want 1", jumps); end
    wait_fall(len);
    total++; if (len != 4 * 25) begin bad++; $display("FAIL halt_len got %0d want %0d", len, 4 * 25); end
  endtask
  task automatic test_mode_switch();
    bit ok;
    int len;
    exp_q.delete();
    push(192, 64); push(192, 192); push(64, 192); push(64, 64);
    jumps = 0;
    repeat (5000) @(negedge clk_fast);
    startgame = 1'b1;
    wait_rise(1100 * 25, ok);
    total++; if (!ok || $time - rel_t > 1100 * 250) begin bad++; $display("FAIL second_halt_time got %0t want <=%0d", $time - rel_t, 1100 * 250); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL switch_title_points got %0d left want 0", exp_q.size()); end
    total++; if (jumps != 0) begin bad++; $display("FAIL switch_jumps got %0d want 0", jumps); end
    wait_fall(len);
  endtask
  task automatic test_game();
    bit ok;
    int n, len;
    time t0;
    exp_q.delete();
    push_border();
    push(146, 150); push(154, 150); push(150, 146); push(150, 154);
    jumps = 0;
    t0 = $time;
    n = 0;
    while (exp_q.size() > 3 && n < 1100 * 25) begin
      @(negedge clk_fast);
      n++;
    end
    total++; if (exp_q.size() != 3) begin bad++; $display("FAIL cross_start got %0d left want 3", exp_q.size()); end
    xcursor = 8'd2;
    ycursor = 8'd253;
    wait_rise(1100 * 25, ok);
    total++; if (!ok || $time - t0 > 1060 * 250) begin bad++; $display("FAIL game_halt_time got %0t want <=%0d", $time - t0, 1060 * 250); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL game_points got %0d left want 0", exp_q.size()); end
    total++; if (jumps != 3) begin bad++; $display("FAIL game_jumps got %0d want 3", jumps); end
    wait_fall(len);
  endtask
  task automatic test_clamp();
    bit ok;
    exp_q.delete();
    push_border();
    push(0, 253); push(6, 253); push(2, 249); push(2, 255);
    jumps = 0;
    wait_rise(1100 * 25, ok);
    total++; if (!ok) begin bad++; $display("FAIL clamp_halt got %b want 1", ok); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL clamp_points got %0d left want 0", exp_q.size()); end
    total++; if (jumps != 3) begin bad++; $display("FAIL clamp_jumps got %0d want 3", jumps); end
  endtask
  task automatic test_tick_rate();
    total++; if (min_gap != 250) begin bad++; $display("FAIL min_change_gap got %0t want 250", min_gap); end
    total++; if (viol != 0) begin bad++; $display("FAIL go_halt_overlap got %0d want 0", viol); end
  endtask
  initial begin
    test_reset();
    test_title();
    test_mode_switch();
    test_game();
    test_clamp();
    test_tick_rate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vector_frame_engine.md
Name: vector_frame_engine

Overview:
- Top-level vector-display engine for the NORAD-A game.
- Fetches vector commands from an internal display-list ROM and steps a beam position along them.
- Drives the X and Y DAC channel codes.
- Selects the title frame or the game frame (with a crosshair at the cursor) and signals frame run and frame end.
- Runs entirely in the fast clock domain; an internal divider produces the beam-step rate.

Parameters:
- ADDRESSWIDTH, 8: display-list ROM address width; the title list is based at 0, the game list at 2**(ADDRESSWIDTH-1).
- DATAWIDTH, 18: ROM word width; word = opcode[17:16], x[15:8], y[7:0].
- OUT_WIDTH, 8: DAC code width; must be >= 8.
- TICK_DIV, 25: clk_fast cycles per beam step (100 MHz / 25 = 4 MHz).
- HALT_TICKS, 4: ticks spent in the halt dwell.

Ports:
- clk_fast, in, 1: the only clock; all logic on its rising edge.
- rst, in, 1: asynchronous, active-high reset.
- startgame, in, 1: 0 = title frame, 1 = game frame; sampled at frame start only.
- xcursor, in, 8: crosshair X; sampled when the CURS op executes.
- ycursor, in, 8: crosshair Y; sampled when the CURS op executes.
- go_flag, out, 1: high while a frame is executing.
- halt_flag, out, 1: high during the halt dwell.
- xch, out, OUT_WIDTH: X DAC code.
- ych, out, OUT_WIDTH: Y DAC code.

Behaviour:
- Tick generation:
  - A counter 0..TICK_DIV-1 produces a one-cycle tick strobe when it wraps.
  - All state and outputs change only on tick cycles.
  - The counter is reset to 0.
- Reset values: xch=0, ych=0, go_flag=0, halt_flag=0, beam=(0,0), state=START.
- Output mapping: xch = {beam_x, (OUT_WIDTH-8) zeros}; ych likewise. Outputs are registered.
- Opcodes:
  - 00 MOVE: beam jumps to (x,y) in one tick.
  - 01 LINE: beam steps to (x,y).
  - 10 CURS: draws the crosshair.
  - 11 HALT: ends the frame.
- State machine, one transition per tick:
  - START: latch mode = startgame; pc = 0 (title) or 2**(ADDRESSWIDTH-1) (game); go_flag <= 1; -> FETCH.
  - FETCH: synchronous ROM read of pc; pc++; -> EXEC.
  - EXEC: decode. MOVE: load beam, -> FETCH. LINE: -> STEP, or -> FETCH if target equals beam. CURS: -> CROSS. HALT: go_flag <= 0, halt_flag <= 1, -> HALT.
  - STEP: Bresenham; each tick advance one unit on the dominant axis and the minor axis per error term; endpoint reached exactly; -> FETCH on arrival.
  - CROSS: latch xcursor/ycursor. Run internal sub-sequence MOVE(xc-4,yc), LINE(xc+4,yc), MOVE(xc,yc-4), LINE(xc,yc+4), using the STEP datapath. Offsets clamp to 0..255 (no wrap). -> FETCH.
  - HALT: hold the beam for HALT_TICKS ticks, then halt_flag <= 0, -> START. The next frame repeats indefinitely, so halt_flag rises once per frame.
- ROM contents are fixed constants.
  - Title at 0: MOVE(64,64), LINE(192,64), LINE(192,192), LINE(64,192), LINE(64,64), HALT.
  - Game at base: MOVE(0,0), LINE(255,0), LINE(255,255), LINE(0,255), LINE(0,0), CURS, HALT.
  - Unused words = HALT, so a runaway pc halts.
- Boundaries:
  - pc wraps modulo 2**ADDRESSWIDTH.
  - A startgame change mid-frame takes effect at the next START.
  - Cursor changes during CROSS are ignored until the next CURS.
  - Assertion of rst at any time returns all outputs to reset values within the same cycle (asynchronous).
  - go_flag and halt_flag are never both 1.
- Frame length:
  - Title frame ≤ 540 ticks.
  - Game frame ≤ 1060 ticks.

Test Plan:
1. Reset: hold rst=1 mid-frame → xch=ych=0, go_flag=0, halt_flag=0 immediately; after release, go_flag=1 within 2*TICK_DIV clk_fast cycles.
2. Title frame, startgame=0, cursor (150,150): samples include (64,64), (192,64), (192,192), (64,192) in order; every step changes x or y by ≤1; halt_flag rises within 540 ticks and stays high for exactly 4 ticks; the second halt rising edge arrives within 1100 ticks of reset.
3. Game frame, startgame=1, cursor (150,150): border corners (0,0), (255,0), (255,255), (0,255) are visited; crosshair spans x=146..154 at y=150 and y=146..154 at x=150; then halt_flag pulses.
4. Clamping: startgame=1, cursor (2,253) → horizontal crosshair x from 0 to 6; vertical crosshair y from 249 to 255; no wrap values appear.
5. Mode switch: toggle startgame 0→1 mid title frame → the current frame completes as title; the next frame after halt is the game frame.
6. Tick rate: measure → xch/ych change at most once per 25 clk_fast cycles; go_flag=0 exactly while halt_flag=1.
